i2c_xfer_seq: RTL and testbench

Autonomous transaction sequencer sitting directly upstream of the I2C master register block, driving its Avalon-style register port. It initialises prescaler and control registers and drains a command FIFO of byte-level I2C operations. For each operation it polls status, captures received data and ACK/arbitration status, and pushes a response word into a response FIFO, so the CPU no longer bit-bangs the register interface.

---
 rtl/i2c_xfer_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: autonomous transaction sequencer in front of the I2C master
// register block. Initialises PRE/CTRL, drains a command FIFO of byte-level
// operations, polls STATUS and pushes {al, rxack, rx} responses.
// Optional build macro: I2C_SEQ_ABORT_ON_AL_EN (flush queued commands after
// a response reporting arbitration loss).
module i2c_xfer_seq #(
   parameter int CMD_DEPTH = 8,
   parameter int RSP_DEPTH = 8,
   parameter int POLL_GAP  = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        enable_i,
   input  logic [15:0] prescale_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [12:0] cmd_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [9:0]  rsp_data_o,
   output logic        busy_o,
   output logic [7:0]  m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic        m_write_o,
   output logic        m_chipsel_o,
   input  logic [31:0] m_rdata_i
);

   localparam int CA = $clog2(CMD_DEPTH);
   localparam int RA = $clog2(RSP_DEPTH);
   localparam logic [CA:0] C_ONE = {{CA{1'b0}}, 1'b1};
   localparam logic [RA:0] R_ONE = {{RA{1'b0}}, 1'b1};
   localparam int GAP_EFF = (POLL_GAP < 2) ? 2 : POLL_GAP;
   localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);

   localparam logic [7:0] ADDR_PRE    = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h04;
   localparam logic [7:0] ADDR_RX     = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h0C;
   localparam logic [7:0] ADDR_TX     = 8'h10;
   localparam logic [7:0] ADDR_CMD    = 8'h14;

`ifdef I2C_SEQ_ABORT_ON_AL_EN
   localparam logic ABORT_ON_AL = 1'b1;
`else
   localparam logic ABORT_ON_AL = 1'b0;
`endif

   typedef enum logic [3:0] {
      ST_IDLE, ST_INIT_PRE, ST_INIT_CTRL, ST_READY, ST_DIS, ST_WR_TX, ST_WR_CMD,
      ST_POLL_WAIT, ST_POLL_RD, ST_POLL_CHK, ST_RD_RX, ST_RX_CAP, ST_CLR_IRQ, ST_PUSH
   } state_t;

   state_t      state_r;
   logic [4:0]  flags_r;       // {sta, sto, rd, wr, ack} of the active command
   logic        al_r;
   logic        rxack_r;
   logic [7:0]  rx_r;
   logic [15:0] poll_cnt_r;

   logic [12:0] cmd_mem_r [CMD_DEPTH];
   logic [CA:0] cmd_wr_ptr_r;
   logic [CA:0] cmd_rd_ptr_r;
   logic [9:0]  rsp_mem_r [RSP_DEPTH];
   logic [RA:0] rsp_wr_ptr_r;
   logic [RA:0] rsp_rd_ptr_r;

   logic        cmd_empty_s;
   logic        cmd_full_s;
   logic        cmd_push_s;
   logic        cmd_pop_s;
   logic        cmd_flush_s;
   logic [12:0] cmd_head_s;
   logic        rsp_empty_s;
   logic        rsp_full_s;
   logic        rsp_push_s;
   logic        rsp_pop_s;
   logic        rdata_unused_s;

   assign cmd_empty_s = (cmd_wr_ptr_r == cmd_rd_ptr_r);
   assign cmd_full_s  = (cmd_wr_ptr_r[CA] != cmd_rd_ptr_r[CA]) &&
                        (cmd_wr_ptr_r[CA-1:0] == cmd_rd_ptr_r[CA-1:0]);
   assign cmd_ready_o = ~rstn_i & ~cmd_full_s;
   assign cmd_head_s  = cmd_mem_r[cmd_rd_ptr_r[CA-1:0]];
   assign cmd_pop_s   = (state_r == ST_READY) & enable_i & ~cmd_empty_s;
   assign cmd_push_s  = cmd_valid_i & cmd_ready_o & ~cmd_flush_s;

   assign rsp_empty_s = (rsp_wr_ptr_r == rsp_rd_ptr_r);
   assign rsp_full_s  = (rsp_wr_ptr_r[RA] != rsp_rd_ptr_r[RA]) &&
                        (rsp_wr_ptr_r[RA-1:0] == rsp_rd_ptr_r[RA-1:0]);
   assign rsp_valid_o = ~rsp_empty_s;
   assign rsp_data_o  = rsp_empty_s ? 10'h000 : rsp_mem_r[rsp_rd_ptr_r[RA-1:0]];
   assign rsp_pop_s   = rsp_valid_o & rsp_ready_i;
   // A full FIFO still accepts a push when its head leaves in the same cycle
   assign rsp_push_s  = (state_r == ST_PUSH) & (~rsp_full_s | rsp_pop_s);
   assign cmd_flush_s = rsp_push_s & al_r & ABORT_ON_AL;

   assign busy_o = (state_r != ST_IDLE) && (state_r != ST_READY);
   assign rdata_unused_s = ^m_rdata_i[31:8];

   // Command FIFO storage
   always_ff @(posedge clk_i) begin
      if (cmd_push_s) begin
         cmd_mem_r[cmd_wr_ptr_r[CA-1:0]] <= cmd_data_i;
      end
   end

   // Command FIFO pointers; a flush drops everything including this cycle's push
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         cmd_wr_ptr_r <= '0;
         cmd_rd_ptr_r <= '0;
      end else if (cmd_flush_s) begin
         cmd_rd_ptr_r <= cmd_wr_ptr_r;
      end else begin
         if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + C_ONE;
         if (cmd_pop_s)  cmd_rd_ptr_r <= cmd_rd_ptr_r + C_ONE;
      end
   end

   // Response FIFO storage
   always_ff @(posedge clk_i) begin
      if (rsp_push_s) begin
         rsp_mem_r[rsp_wr_ptr_r[RA-1:0]] <= {al_r, rxack_r, rx_r};
      end
   end

   // Response FIFO pointers
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         rsp_wr_ptr_r <= '0;
         rsp_rd_ptr_r <= '0;
      end else begin
         if (rsp_push_s) rsp_wr_ptr_r <= rsp_wr_ptr_r + R_ONE;
         if (rsp_pop_s)  rsp_rd_ptr_r <= rsp_rd_ptr_r + R_ONE;
      end
   end

   // Sequencer FSM; bus strobes are registered so they coincide with the access state
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         state_r     <= ST_IDLE;
         flags_r     <= 5'b00000;
         al_r        <= 1'b0;
         rxack_r     <= 1'b0;
         rx_r        <= 8'h00;
         poll_cnt_r  <= 16'h0000;
         m_addr_o    <= 8'h00;
         m_wdata_o   <= 32'h0000_0000;
         m_write_o   <= 1'b0;
         m_chipsel_o <= 1'b0;
      end else begin
         m_addr_o    <= 8'h00;
         m_wdata_o   <= 32'h0000_0000;
         m_write_o   <= 1'b0;
         m_chipsel_o <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (enable_i) begin
                  state_r     <= ST_INIT_PRE;
                  m_chipsel_o <= 1'b1;
                  m_write_o   <= 1'b1;
                  m_addr_o    <= ADDR_PRE;
                  m_wdata_o   <= {16'h0000, prescale_i};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_INIT_PRE: begin
               state_r     <= ST_INIT_CTRL;
               m_chipsel_o <= 1'b1;
               m_write_o   <= 1'b1;
               m_addr_o    <= ADDR_CTRL;
               m_wdata_o   <= 32'h0000_0080;
            end
            ST_INIT_CTRL: state_r <= ST_READY;
            ST_READY: begin
               if (!enable_i) begin
                  state_r     <= ST_DIS;
                  m_chipsel_o <= 1'b1;
                  m_write_o   <= 1'b1;
                  m_addr_o    <= ADDR_CTRL;
               end else if (!cmd_empty_s) begin
                  flags_r <= cmd_head_s[12:8];
                  al_r    <= 1'b0;
                  rxack_r <= 1'b0;
                  rx_r    <= 8'h00;
                  if (cmd_head_s[12:9] == 4'b0000) begin
                     state_r <= ST_PUSH;
                  end else begin
                     state_r     <= ST_WR_TX;
                     m_chipsel_o <= 1'b1;
                     m_write_o   <= 1'b1;
                     m_addr_o    <= ADDR_TX;
                     m_wdata_o   <= {24'h000000, cmd_head_s[7:0]};
                  end
               end else begin
                  state_r <= ST_READY;
               end
            end
            ST_DIS: state_r <= ST_IDLE;
            ST_WR_TX: begin
               state_r     <= ST_WR_CMD;
               m_chipsel_o <= 1'b1;
               m_write_o   <= 1'b1;
               m_addr_o    <= ADDR_CMD;
               m_wdata_o   <= {24'h000000, flags_r, 3'b000};
            end
            ST_WR_CMD: begin
               state_r    <= ST_POLL_WAIT;
               poll_cnt_r <= 16'h0000;
            end
            ST_POLL_WAIT: begin
               if (poll_cnt_r == GAP_LAST) begin
                  state_r     <= ST_POLL_RD;
                  m_chipsel_o <= 1'b1;
                  m_addr_o    <= ADDR_STATUS;
               end else begin
                  poll_cnt_r <= poll_cnt_r + 16'd1;
               end
            end
            ST_POLL_RD: state_r <= ST_POLL_CHK;
            ST_POLL_CHK: begin
               if (m_rdata_i[0] && !m_rdata_i[1]) begin
                  rxack_r <= m_rdata_i[7];
                  al_r    <= m_rdata_i[5];
                  if (flags_r[2]) begin
                     state_r     <= ST_RD_RX;
                     m_chipsel_o <= 1'b1;
                     m_addr_o    <= ADDR_RX;
                  end else begin
                     state_r     <= ST_CLR_IRQ;
                     m_chipsel_o <= 1'b1;
                     m_write_o   <= 1'b1;
                     m_addr_o    <= ADDR_CMD;
                     m_wdata_o   <= 32'h0000_0001;
                  end
               end else begin
                  state_r    <= ST_POLL_WAIT;
                  poll_cnt_r <= 16'h0000;
               end
            end
            ST_RD_RX: state_r <= ST_RX_CAP;
            ST_RX_CAP: begin
               rx_r        <= m_rdata_i[7:0];
               state_r     <= ST_CLR_IRQ;
               m_chipsel_o <= 1'b1;
               m_write_o   <= 1'b1;
               m_addr_o    <= ADDR_CMD;
               m_wdata_o   <= 32'h0000_0001;
            end
            ST_CLR_IRQ: state_r <= ST_PUSH;
            ST_PUSH: begin
               if (rsp_push_s) begin
                  state_r <= ST_READY;
               end else begin
                  state_r <= ST_PUSH;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Self-checking bench for i2c_xfer_seq: register-bus slave model plus
// scoreboards of expected bus accesses and responses.
module tb_i2c_xfer_seq;

   localparam int CMD_DEPTH = 8;
   localparam int RSP_DEPTH = 8;
   localparam int POLL_GAP  = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        enable_i;
   logic [15:0] prescale_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [12:0] cmd_data_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [9:0]  rsp_data_o;
   logic        busy_o;
   logic [7:0]  m_addr_o;
   logic [31:0] m_wdata_o;
   logic        m_write_o;
   logic        m_chipsel_o;
   logic [31:0] m_rdata_i = 32'h0000_0000;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;
   int tx_cyc = 0;
   int rsp_cyc = 0;

   logic [40:0] exp_bus_q [$];
   logic [9:0]  exp_rsp_q [$];
   logic [7:0]  status_q  [$];
   logic [7:0]  rx_q      [$];

   i2c_xfer_seq #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .POLL_GAP(POLL_GAP)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .prescale_i(prescale_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_data_i(cmd_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_write_o(m_write_o),
      .m_chipsel_o(m_chipsel_o), .m_rdata_i(m_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Cycle counter for latency measurement
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [31:0] d);
      exp_bus_q.push_back({1'b1, a, d});
   endtask

   task automatic exp_rd(input logic [7:0] a);
      exp_bus_q.push_back({1'b0, a, 32'h0000_0000});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push_cmd(input logic [12:0] c);
      int n;
      n = 0;
      cmd_valid_i = 1'b1;
      cmd_data_i  = c;
      @(negedge clk_i);
      while (!cmd_ready_o && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("cmd_accept", cmd_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   // Queue expectations for one command, then push it
   task automatic queue_cmd(input logic [12:0] c, input logic [7:0] cmd_reg, input int n_busy,
                            input logic [7:0] busy_st, input logic [7:0] fin_st,
                            input logic [7:0] rx, input logic [9:0] rsp);
      if (c[12:9] != 4'b0000) begin
         exp_wr(8'h10, {24'h000000, c[7:0]});
         exp_wr(8'h14, {24'h000000, cmd_reg});
         for (int i = 0; i < n_busy; i++) begin
            exp_rd(8'h0C);
            status_q.push_back(busy_st);
         end
         exp_rd(8'h0C);
         status_q.push_back(fin_st);
         if (c[10]) begin
            exp_rd(8'h08);
            rx_q.push_back(rx);
         end
         exp_wr(8'h14, 32'h0000_0001);
      end
      exp_rsp_q.push_back(rsp);
      push_cmd(c);
   endtask

   task automatic drain(input string tag, input int bound);
      int n;
      n = 0;
      while ((exp_bus_q.size() != 0 || exp_rsp_q.size() != 0) && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      check_eq(tag, exp_bus_q.size() + exp_rsp_q.size(), 0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_bus(input string tag, input int bound);
      int n;
      n = 0;
      while (exp_bus_q.size() != 0 && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      check_eq(tag, exp_bus_q.size(), 0);
   endtask

   // Register-block slave model: read data returned one cycle after the strobe
   always @(posedge clk_i) begin
      if (m_chipsel_o && !m_write_o && m_addr_o == 8'h0C) begin
         if (status_q.size() != 0) m_rdata_i <= {24'h000000, status_q.pop_front()};
         else m_rdata_i <= 32'h0000_0002;
      end else if (m_chipsel_o && !m_write_o && m_addr_o == 8'h08) begin
         if (rx_q.size() != 0) m_rdata_i <= {24'h000000, rx_q.pop_front()};
         else m_rdata_i <= 32'h0000_0000;
      end else begin
         m_rdata_i <= 32'hA5A5_A5A4;
      end
   end

   // Bus and response monitors compare against the scoreboards
   always @(negedge clk_i) begin
      if (!rstn_i && m_chipsel_o) begin
         check_eq("bus_expected", exp_bus_q.size() != 0, 1'b1);
         if (exp_bus_q.size() != 0)
            check_eq("bus_access", {m_write_o, m_addr_o, m_wdata_o}, exp_bus_q.pop_front());
         if (m_write_o && m_addr_o == 8'h10) tx_cyc <= cyc;
      end
      if (!rstn_i && rsp_valid_o && rsp_ready_i) begin
         check_eq("rsp_expected", exp_rsp_q.size() != 0, 1'b1);
         if (exp_rsp_q.size() != 0) check_eq("rsp_data", rsp_data_o, exp_rsp_q.pop_front());
         rsp_cyc <= cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] c;
      rstn_i = 1'b1;
      enable_i = 1'b0;
      prescale_i = 16'h0031;
      cmd_valid_i = 1'b0;
      cmd_data_i = 13'h0000;
      rsp_ready_i = 1'b1;

      // Reset state
      repeat (3) @(negedge clk_i);
      check_eq("rst_cmd_ready", cmd_ready_o, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
      check_eq("rst_rsp_data", rsp_data_o, 10'h000);
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_bus", {m_chipsel_o, m_write_o, m_addr_o, m_wdata_o}, 42'h0);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      @(negedge clk_i);
      check_eq("post_rst_cmd_ready", cmd_ready_o, 1'b1);
      @(posedge clk_i);
      #1;

      // Init: PRE then CTRL on consecutive cycles
      exp_wr(8'h00, 32'h0000_0031);
      exp_wr(8'h04, 32'h0000_0080);
      enable_i = 1'b1;
      @(negedge clk_i);
      check_eq("init_idle_busy", busy_o, 1'b0);
      @(negedge clk_i);
      check_eq("init_pre_addr", {m_chipsel_o, m_write_o, m_addr_o}, {2'b11, 8'h00});
      @(negedge clk_i);
      check_eq("init_ctrl_addr", {m_chipsel_o, m_write_o, m_addr_o}, {2'b11, 8'h04});
      @(negedge clk_i);
      check_eq("init_ready_busy", busy_o, 1'b0);
      @(posedge clk_i);
      #1;
      drain("init_drain", 20);

      // Write byte: two busy polls, then done
      queue_cmd(13'h12A0, 8'h90, 2, 8'h02, 8'h01, 8'h00, 10'h000);
      drain("wr_byte_drain", 200);

      // Read byte with NACK-to-send, single poll; check latency
      queue_cmd(13'h0D00, 8'h68, 0, 8'h02, 8'h81, 8'h5C, 10'h15C);
      drain("rd_byte_drain", 200);
      check_eq("rd_latency", rsp_cyc - tx_cyc, 8 + POLL_GAP);

      // Command without bus operation
      queue_cmd(13'h0055, 8'h00, 0, 8'h02, 8'h01, 8'h00, 10'h000);
      drain("null_drain", 50);

      // Read with irq&tip busy status, then al+rxack
      queue_cmd(13'h0400, 8'h20, 1, 8'h03, 8'hA1, 8'h3C, 10'h33C);
      drain("rd_al_drain", 200);

      // Backpressure: RSP_DEPTH+1 reads with responses held
      rsp_ready_i = 1'b0;
      for (int i = 0; i < RSP_DEPTH + 1; i++) begin
         c = 13'h0400 | 13'(i);
         queue_cmd(c, 8'h20, 0, 8'h02, (i % 2 == 1) ? 8'h81 : 8'h01, 8'h60 + 8'(i),
                   {1'b0, (i % 2 == 1), 8'h60 + 8'(i)});
      end
      wait_bus("bp_bus", 600);
      tick(20);
      check_eq("bp_stalled_busy", busy_o, 1'b1);
      check_eq("bp_rsp_valid", rsp_valid_o, 1'b1);
      check_eq("bp_pending", exp_rsp_q.size(), RSP_DEPTH + 1);
      rsp_ready_i = 1'b1;
      drain("bp_drain", 100);
      tick(2);
      check_eq("bp_idle", busy_o, 1'b0);

      // Arbitration loss on first of three commands
      queue_cmd(13'h0211, 8'h10, 0, 8'h02, 8'h21, 8'h00, 10'h200);
`ifdef I2C_SEQ_ABORT_ON_AL_EN
      push_cmd(13'h0222);
      push_cmd(13'h0233);
`else
      queue_cmd(13'h0222, 8'h10, 0, 8'h02, 8'h01, 8'h00, 10'h000);
      queue_cmd(13'h0233, 8'h10, 0, 8'h02, 8'h01, 8'h00, 10'h000);
`endif
      drain("al_drain", 300);
      tick(30);
      check_eq("al_settled_busy", busy_o, 1'b0);
      check_eq("al_cmd_ready", cmd_ready_o, 1'b1);
      status_q.delete();

      // Disable writes CTRL=0; queued command is retained across disable
      exp_wr(8'h04, 32'h0000_0000);
      enable_i = 1'b0;
      drain("dis_drain", 20);
      tick(2);
      check_eq("dis_busy", busy_o, 1'b0);
      exp_rsp_q.push_back(10'h000);
      push_cmd(13'h0000);
      tick(10);
      check_eq("dis_no_rsp", rsp_valid_o, 1'b0);
      prescale_i = 16'h1234;
      exp_wr(8'h00, 32'h0000_1234);
      exp_wr(8'h04, 32'h0000_0080);
      enable_i = 1'b1;
      drain("retain_drain", 40);

      // Reset while in POLL_WAIT: no iack, queued commands lost
      for (int i = 0; i < 30; i++) status_q.push_back(8'h02);
      exp_wr(8'h10, 32'h0000_0044);
      exp_wr(8'h14, 32'h0000_0010);
      push_cmd(13'h0244);
      push_cmd(13'h0255);
      wait_bus("rp_bus", 40);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      enable_i = 1'b0;
      @(negedge clk_i);
      check_eq("rp_strobes", {m_chipsel_o, m_write_o}, 2'b00);
      check_eq("rp_rsp_valid", rsp_valid_o, 1'b0);
      check_eq("rp_busy", busy_o, 1'b0);
      check_eq("rp_cmd_ready_in_rst", cmd_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      status_q.delete();
      @(negedge clk_i);
      check_eq("rp_cmd_ready", cmd_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      exp_wr(8'h00, 32'h0000_1234);
      exp_wr(8'h04, 32'h0000_0080);
      enable_i = 1'b1;
      drain("rp_reinit", 30);
      tick(40);
      check_eq("rp_cmds_lost", busy_o, 1'b0);
      check_eq("rp_no_rsp", rsp_valid_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
